// File: rtl/hamming_pkg.sv
// Shared definitions for the (12,8) Hamming link: widths, syndrome type,
// data position map and the syndrome function.
package hamming_pkg;

  localparam int unsigned CW_W   = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYN_W  = 4;

  typedef logic [SYN_W-1:0] syn_t;

  localparam syn_t SYN_NONE     = 4'd0;
  localparam syn_t SYN_MAX_CORR = 4'd12;

  // Codeword positions carrying payload, MSB first; parity sits at 1,2,4,8.
  localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

  // Decoder result handed from the corrector to the output stage.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    syn_t              syn;
    logic              corr;
    logic              uncorr;
  } dec_result_t;

  // Position p (1..12) lives in vector bit 12-p.
  function automatic logic [3:0] pos_idx(input int unsigned p);
    return 4'(CW_W - p);
  endfunction

  // Each set position contributes its own index to the syndrome.
  function automatic syn_t ham12_syndrome(input logic [CW_W-1:0] cw);
    syn_t s;
    s = SYN_NONE;
    for (int unsigned p = 1; p <= CW_W; p++) begin
      if (cw[pos_idx(p)]) s = s ^ syn_t'(p);
    end
    return s;
  endfunction

endpackage

// File: rtl/hamming12_correct.sv
// Combinational single-error corrector for one 12-bit codeword.
module hamming12_correct
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0] cw_i,
  output dec_result_t     res_c_o
);

  syn_t            syn_c;
  logic            corr_c;
  logic [CW_W-1:0] fixed_c;

  // Syndrome, flip of the addressed position and payload extraction.
  always_comb begin
    res_c_o = '0;
    syn_c   = ham12_syndrome(cw_i);
    corr_c  = (syn_c != SYN_NONE) && (syn_c <= SYN_MAX_CORR);
    fixed_c = cw_i;
    if (corr_c) fixed_c[4'(SYN_MAX_CORR - syn_c)] = ~cw_i[4'(SYN_MAX_CORR - syn_c)];
    for (int unsigned i = 0; i < DATA_W; i++) begin
      res_c_o.data[3'(DATA_W - 1 - i)] = fixed_c[pos_idx(DATA_POS[i])];
    end
    res_c_o.syn    = syn_c;
    res_c_o.corr   = corr_c;
    res_c_o.uncorr = syn_c > SYN_MAX_CORR;
  end

endmodule

// File: rtl/hamming_rx_deserializer.sv
// Serial receive end of the (12,8) Hamming link: framing, correction,
// one-deep output holding register and saturating link-quality counters.
module hamming_rx_deserializer
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_bit,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic [DATA_W-1:0] m_data,
  output logic              m_corr,
  output logic              m_uncorr,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr,
  output logic [CNT_W-1:0]  cnt_drop,
  output logic [CNT_W-1:0]  cnt_frame
);

  localparam int unsigned SR_W     = CW_W - 1;
  localparam int unsigned BITCNT_W = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic                dec_pend_q, dec_pend_d;
  logic                frame_err_c;

  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_corr_q, m_corr_d;
  logic                m_uncorr_q, m_uncorr_d;
  logic                m_valid_q, m_valid_d;
  logic                load_c, drop_c;

  logic [CNT_W-1:0]    cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0]    cnt_uncorr_q, cnt_uncorr_d;
  logic [CNT_W-1:0]    cnt_drop_q, cnt_drop_d;
  logic [CNT_W-1:0]    cnt_frame_q, cnt_frame_d;

  dec_result_t         dec_res;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  hamming12_correct u_correct (
    .cw_i    (cw_q),
    .res_c_o (dec_res)
  );

  // Receive FSM: SOF always restarts a word; the 12th bit hands off to the decoder.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    sr_d        = sr_q;
    cw_d        = cw_q;
    dec_pend_d  = 1'b0;
    frame_err_c = 1'b0;
    if (s_valid) begin
      if (s_sof) begin
        frame_err_c = (state_q == ST_SHIFT);
        sr_d        = SR_W'(s_bit);
        bitcnt_d    = BITCNT_W'(1);
        state_d     = ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
        if (bitcnt_q == BITCNT_W'(CW_W - 1)) begin
          cw_d       = {sr_q, s_bit};
          dec_pend_d = 1'b1;
          bitcnt_d   = '0;
          state_d    = ST_IDLE;
        end else begin
          sr_d     = {sr_q[SR_W-2:0], s_bit};
          bitcnt_d = bitcnt_q + BITCNT_W'(1);
        end
      end
    end
  end

  // Output holding register: load when empty or draining, otherwise drop.
  always_comb begin
    load_c     = dec_pend_q && (!m_valid_q || m_ready);
    drop_c     = dec_pend_q && m_valid_q && !m_ready;
    m_data_d   = m_data_q;
    m_corr_d   = m_corr_q;
    m_uncorr_d = m_uncorr_q;
    m_valid_d  = m_valid_q;
    if (load_c) begin
      m_data_d   = dec_res.data;
      m_corr_d   = dec_res.corr;
      m_uncorr_d = dec_res.uncorr;
      m_valid_d  = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d  = 1'b0;
    end
  end

  // Saturating event counters; clear wins over any increment.
  always_comb begin
    cnt_corr_d   = sat_inc(cnt_corr_q, load_c && dec_res.corr);
    cnt_uncorr_d = sat_inc(cnt_uncorr_q, load_c && dec_res.uncorr);
    cnt_drop_d   = sat_inc(cnt_drop_q, drop_c);
    cnt_frame_d  = sat_inc(cnt_frame_q, frame_err_c);
    if (clr_cnt) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
      cnt_drop_d   = '0;
      cnt_frame_d  = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      sr_q         <= '0;
      cw_q         <= '0;
      dec_pend_q   <= 1'b0;
      m_data_q     <= '0;
      m_corr_q     <= 1'b0;
      m_uncorr_q   <= 1'b0;
      m_valid_q    <= 1'b0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
      cnt_drop_q   <= '0;
      cnt_frame_q  <= '0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      sr_q         <= sr_d;
      cw_q         <= cw_d;
      dec_pend_q   <= dec_pend_d;
      m_data_q     <= m_data_d;
      m_corr_q     <= m_corr_d;
      m_uncorr_q   <= m_uncorr_d;
      m_valid_q    <= m_valid_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
      cnt_drop_q   <= cnt_drop_d;
      cnt_frame_q  <= cnt_frame_d;
    end
  end

  // A zero syndrome must never come with a flag, and a flag needs a nonzero syndrome.
  a_flag_syn : assert property (@(posedge clk) disable iff (!rst_n)
    dec_pend_q |-> ((dec_res.syn == SYN_NONE) == !(dec_res.corr || dec_res.uncorr)));

  assign m_data     = m_data_q;
  assign m_corr     = m_corr_q;
  assign m_uncorr   = m_uncorr_q;
  assign m_valid    = m_valid_q;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;
  assign cnt_drop   = cnt_drop_q;
  assign cnt_frame  = cnt_frame_q;

endmodule
